// File: rtl/proc_pkg.sv
// Shared types and constants for the byte-coded multi-cycle core.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_ADC,
        ALU_SUB,
        ALU_SBC,
        ALU_OR,
        ALU_AND,
        ALU_XOR,
        ALU_CP
    } alu_op_t;

    // Jump condition codes (high nibble of a JP opcode)
    localparam logic [3:0] CC_NEVER  = 4'h0;
    localparam logic [3:0] CC_Z      = 4'h6;
    localparam logic [3:0] CC_C      = 4'h7;
    localparam logic [3:0] CC_ALWAYS = 4'h8;
    localparam logic [3:0] CC_NZ     = 4'hE;
    localparam logic [3:0] CC_NC     = 4'hF;

    // Low-nibble opcode classes
    localparam logic [3:0] OPC_LDC   = 4'hC;
    localparam logic [3:0] OPC_LDR   = 4'h8;
    localparam logic [3:0] OPC_ALU   = 4'h2;
    localparam logic [3:0] OPC_JP    = 4'hD;
    localparam logic [3:0] OPC_SIZE1 = 4'hF;

    localparam logic [7:0] OP_HALT   = 8'h7F;

    // Instruction length in bytes, known from byte 0 alone
    function automatic logic [1:0] instr_size(input logic [7:0] b0);
        if (b0[3:0] == OPC_SIZE1) begin
            return 2'd1;
        end else if (b0[3:0] == OPC_JP) begin
            return 2'd3;
        end else begin
            return 2'd2;
        end
    endfunction

endpackage

// File: rtl/proc_alu.sv
// 8-bit ALU producing result plus Z/C; logic ops pass the incoming carry through.
// Latency: purely combinational.
// Backpressure: none.
module proc_alu
    import proc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  alu_op_t    op,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);

    logic [8:0] wide;

    // Bit 8 of the 9-bit sum/difference is the carry (add) or borrow (sub)
    always_comb begin
        wide = '0;
        c    = cin;
        case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                c    = wide[8];
            end
            ALU_ADC: begin
                wide = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                c    = wide[8];
            end
            ALU_SUB, ALU_CP: begin
                wide = {1'b0, a} - {1'b0, b};
                c    = wide[8];
            end
            ALU_SBC: begin
                wide = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                c    = wide[8];
            end
            ALU_OR:  wide = {1'b0, a | b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        result = wide[7:0];
        z      = (wide[7:0] == 8'd0);
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle byte-coded core: fetch 1..3 bytes, then one EXEC cycle.
// Latency: (2 + wait states) cycles per byte fetched, plus one EXEC cycle.
// Backpressure: fetch holds in WAIT with memAddr stable until memReady.
module proc_core
    import proc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    input  logic                  memReady,
    input  logic [7:0]            memDataRead,
    output logic                  halted,
    output logic                  flagZ,
    output logic                  flagC
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            byte_idx;
    logic [7:0]            ir, b1, b2;
    logic [7:0]            regs [NUM_REGS];
    logic                  flag_z, flag_c;

    logic [1:0]            cur_size;
    logic                  more_bytes;
    logic [IDXW-1:0]       rh, ra, rb;
    logic                  alu_vld;
    alu_op_t               alu_op;
    logic [7:0]            alu_res;
    logic                  alu_z, alu_c;
    logic                  jp_take;
    logic [15:0]           jp_word;

    assign memAddr = pc;
    assign halted  = (state == ST_HALT);
    assign flagZ   = flag_z;
    assign flagC   = flag_c;

    assign rh      = ir[4 +: IDXW];
    assign ra      = b1[4 +: IDXW];
    assign rb      = b1[0 +: IDXW];
    assign jp_word = {b1, b2};

    // Size is taken from the byte arriving now when it is byte 0, else from the latched opcode
    assign cur_size   = (byte_idx == 2'd0) ? instr_size(memDataRead) : instr_size(ir);
    assign more_bytes = ((byte_idx + 2'd1) < cur_size);

    proc_alu u_alu (
        .a      (regs[ra]),
        .b      (regs[rb]),
        .cin    (flag_c),
        .op     (alu_op),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    // Decode the latched opcode: ALU group membership and jump condition
    always_comb begin
        alu_vld = (ir[3:0] == OPC_ALU);
        alu_op  = ALU_ADD;
        case (ir[7:4])
            4'h0:    alu_op = ALU_ADD;
            4'h1:    alu_op = ALU_ADC;
            4'h2:    alu_op = ALU_SUB;
            4'h3:    alu_op = ALU_SBC;
            4'h4:    alu_op = ALU_OR;
            4'h5:    alu_op = ALU_AND;
            4'hB:    alu_op = ALU_XOR;
            4'hA:    alu_op = ALU_CP;
            default: alu_vld = 1'b0;
        endcase
        case (ir[7:4])
            CC_ALWAYS: jp_take = 1'b1;
            CC_Z:      jp_take = flag_z;
            CC_NZ:     jp_take = !flag_z;
            CC_C:      jp_take = flag_c;
            CC_NC:     jp_take = !flag_c;
            default:   jp_take = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and strobe; strobe is masked while reset is held
    always_comb begin
        state_nxt = state;
        memStrobe = 1'b0;
        case (state)
            ST_REQ: begin
                memStrobe = !reset;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (memReady) begin
                    state_nxt = more_bytes ? ST_REQ : ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = (ir == OP_HALT) ? ST_HALT : ST_REQ;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_REQ;
        endcase
    end

    // Datapath: byte capture and PC increment in WAIT, architectural update in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= ADDR_WIDTH'(RESET_PC);
            byte_idx <= 2'd0;
            ir       <= 8'd0;
            b1       <= 8'd0;
            b2       <= 8'd0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (memReady) begin
                        case (byte_idx)
                            2'd0:    ir <= memDataRead;
                            2'd1:    b1 <= memDataRead;
                            default: b2 <= memDataRead;
                        endcase
                        pc       <= pc + ADDR_WIDTH'(1);
                        byte_idx <= more_bytes ? (byte_idx + 2'd1) : 2'd0;
                    end
                end
                ST_EXEC: begin
                    if (ir[3:0] == OPC_LDC) begin
                        regs[rh] <= b1;
                    end else if (ir[3:0] == OPC_LDR) begin
                        regs[rh] <= regs[rb];
                    end else if (alu_vld) begin
                        if (alu_op != ALU_CP) begin
                            regs[ra] <= alu_res;
                        end
                        flag_z <= alu_z;
                        flag_c <= alu_c;
                    end else if ((ir[3:0] == OPC_JP) && jp_take) begin
                        pc <= jp_word[ADDR_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/proc_core.md
# proc_core

Parametrised successor to the current 8-bit multi-cycle processor. It fetches Z8-style byte instructions over a request/ready memory port that tolerates any number of wait states. It adds an arithmetic/logic instruction group with Z/C flags, conditional jumps and halt, and has a configurable address width and register count. It sits in the SoC between the program memory and the register file.

## Interface
- ADDR_WIDTH, 16: width of the program counter and `memAddr`. Range 8..16.
- NUM_REGS, 16: number of 8-bit working registers. Power of two, 2..16. Register index = low log2(NUM_REGS) bits of the nibble.
- RESET_PC, 0: PC value after reset.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- memAddr  out  ADDR_WIDTH  fetch address, equal to the PC
- memStrobe  out  1  one-cycle read request pulse
- memReady  in  1  response valid; `memDataRead` sampled in the same cycle
- memDataRead  in  8  fetched byte
- halted  out  1  core stopped by HALT
- flagZ, flagC  out  1 each  current flags

## Operation
- Instruction size is decoded from byte 0:
  - low nibble F → 1 byte
  - low nibble D → 3 bytes
  - all others → 2 bytes
- Instruction set (h = high nibble of byte 0; r1/r2 = high/low nibble of byte 1):
  - FF NOP.
  - 7F HALT.
  - hC ii: LD rh,#ii.
  - h8 xr: LD rh,rr.
  - 02/12/22/32/42/52/B2/A2 r1r2: ADD/ADC/SUB/SBC/OR/AND/XOR/CP with r1 ← r1 op r2. CP writes only the flags.
  - cD hh ll: JP cc,hhll. cc codes: 8 always, 0 never, 6 Z, E NZ, 7 C, F NC; any other cc = never.
  - Jump target is truncated to ADDR_WIDTH.
  - All other opcodes execute as NOP of their decoded size.
- Flags:
  - Z = (result == 0) for every ALU op.
  - C = carry out for ADD/ADC; borrow for SUB/SBC/CP.
  - OR/AND/XOR leave C unchanged. LD and JP change no flags.
  - ADC/SBC use the old C as carry-in/borrow-in.
- State machine with byte counter `byteIdx` (0..2):
  - REQ: assert memStrobe for one cycle, go to WAIT.
  - WAIT: hold until memReady. On memReady, latch the byte into instruction/second/third, then PC+1.
    - More bytes are needed for the decoded size: back to REQ.
    - Otherwise: go to EXEC.
  - EXEC: register/flag write or PC load happens in this cycle. Next state is REQ, or HALT for 7F.
  - HALT: no strobes. It is left only by reset.
- memReady is ignored in every state except WAIT.
- PC wraps modulo 2^ADDR_WIDTH.
- Reset, effective on any cycle including mid-fetch:
  - PC = RESET_PC, state = REQ, byteIdx = 0.
  - All registers = 0, flags = 0, halted = 0, memStrobe = 0.
  - Memory shares this reset, so a response from an aborted request is discarded by the memory.

## Timing
- memStrobe is high in the cycle after reset deasserts, then once per byte.
- The earliest memReady is the cycle after memStrobe. Each extra wait cycle adds exactly one cycle.
- Latency with a 1-wait memory: 1-byte instr 3 cycles, 2-byte 5 cycles, 3-byte 7 cycles (strobe to next strobe).
- A register written in EXEC is readable by the next instruction's EXEC; no hazard exists.
- memAddr is stable from REQ through the WAIT cycle that sees memReady.
- halted rises in the cycle after the HALT EXEC cycle.

## Structure
- Package `proc_pkg` holds:
  - state enum (REQ, WAIT, EXEC, HALT)
  - ALU op enum
  - condition-code constants
  - opcode nibble constants (LDC=C, LDR=8, ALU=2, JP=D, SIZE1=F)
- Sub-module `proc_alu` is purely combinational: a, b, cin, op → result, z, c.
- Decode, register file and FSM live in `proc_core`.

## Test plan
- Program 0C 0A, 1C 14, 02 01, FF, 8D 00 02 with a 1-wait memory → r0 = 0x1E after the first pass, 0x32 after the second, 0x46 after the third. Z = 0 and C = 0 throughout.
- r0 = F0, r1 = 20: ADD 02 01 → r0 = 10, C = 1, Z = 0. Then ADC 12 01 → r0 = 31, C = 0.
- r0 = 05, r1 = 05: CP A2 01 → Z = 1, r0 unchanged. Then 6D 00 40 → PC = 0x0040. With r1 = 06, the jump is not taken and PC advances by 3.
- memReady delayed 0–4 random cycles → same register results as the first scenario. Exactly one memStrobe per byte, and memAddr is stable while waiting.
- 7F at address 3 → halted = 1, and no memStrobe for 50 cycles. Reset restores PC = RESET_PC and clears halted.
- Reset asserted in WAIT of byte 1 of a 3-byte JP → no PC load, PC = RESET_PC, and all registers read 0.
